// File: rtl/flag_pkg.sv
// Shared definitions for the condition-flag controller: flag bit positions,
// ALU opcodes, branch condition codes, FSM states and the opcode-to-update-mask map.
package flag_pkg;

    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_N = 0;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;

    typedef enum logic [2:0] {
        CC_NE = 3'b000,
        CC_EQ = 3'b001,
        CC_GT = 3'b010,
        CC_LT = 3'b011,
        CC_GE = 3'b100,
        CC_LE = 3'b101,
        CC_OV = 3'b110,
        CC_AL = 3'b111
    } cond_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_e;

    // Mask bit order matches the flag vector: {Z, V, N}.
    function automatic logic [2:0] opcode_mask(input logic [3:0] op);
        logic [2:0] m;
        m = 3'b000;
        case (op)
            OP_ADD, OP_SUB:                 m = 3'b111;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: m = 3'b100;
            default:                        m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/flag_cond_eval.sv
// Combinational branch-condition evaluator: maps the effective flags and a
// condition code to a taken decision.
module flag_cond_eval
    import flag_pkg::*;
#(
    parameter int unsigned NFLAGS = 3
) (
    input  logic [NFLAGS-1:0] flags,
    input  logic [2:0]        br_cond,
    output logic              taken
);

    logic w_z;
    logic w_v;
    logic w_n;

    assign w_z = flags[FLAG_Z];
    assign w_v = flags[FLAG_V];
    assign w_n = flags[FLAG_N];

    always_comb begin
        taken = 1'b0;
        case (cond_e'(br_cond))
            CC_NE:   taken = !w_z;
            CC_EQ:   taken = w_z;
            CC_GT:   taken = !w_z && !w_n;
            CC_LT:   taken = w_n;
            CC_GE:   taken = w_z || !w_n;
            CC_LE:   taken = w_z || w_n;
            CC_OV:   taken = w_v;
            CC_AL:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_ctrl.sv
// Condition-flag write arbiter and branch evaluator with a one-cycle write pipeline.
// Define FLAG_CTRL_FWD_EN to forward pending/same-cycle flags to branches instead of stalling.
module flag_ctrl
    import flag_pkg::*;
#(
    parameter int unsigned NFLAGS = 3,
    parameter int unsigned SCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [3:0]        alu_opcode,
    input  logic [NFLAGS-1:0] alu_flags,
    input  logic              ld_valid,
    input  logic [NFLAGS-1:0] ld_flags,
    output logic              ld_ready,
    input  logic              br_valid,
    input  logic [2:0]        br_cond,
    output logic              stall,
    output logic              br_done,
    output logic              br_taken,
    output logic [NFLAGS-1:0] flag_d,
    output logic [NFLAGS-1:0] flag_we,
    output logic              flag_re,
    input  logic [NFLAGS-1:0] flag_q,
    output logic [SCNT_W-1:0] stall_cnt
);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [NFLAGS-1:0]   r_pdata;
    logic [NFLAGS-1:0]   r_pmask;
    logic                r_br_done;
    logic                r_br_taken;
    logic [SCNT_W-1:0]   r_stall_cnt;

    logic [NFLAGS-1:0]   w_mask;
    logic                w_update;
    logic                w_wr;
    logic [NFLAGS-1:0]   w_wr_data;
    logic [NFLAGS-1:0]   w_wr_mask;
    logic [NFLAGS-1:0]   w_eff;
    logic                w_taken;
    logic                w_br_acc;
    logic                w_pend;

    assign w_mask    = NFLAGS'(opcode_mask(alu_opcode));
    assign w_update  = alu_valid && (w_mask != '0);
    assign ld_ready  = !w_update;
    assign w_wr      = w_update || ld_valid;
    assign w_wr_data = w_update ? alu_flags : ld_flags;
    assign w_wr_mask = w_update ? w_mask : '1;
    assign w_pend    = (r_state == ST_PEND);
    assign flag_re   = br_valid;

    always_comb begin
        w_state_nxt = w_wr ? ST_PEND : ST_IDLE;
        flag_we     = '0;
        flag_d      = '0;
        // Gating with rst keeps a reset in PEND from committing the pending write.
        if (w_pend && !rst) begin
            flag_we = r_pmask;
            flag_d  = r_pdata;
        end
    end

`ifdef FLAG_CTRL_FWD_EN
    assign stall = 1'b0;

    // Youngest source wins per bit: same-cycle ALU update, then pending write, then register.
    always_comb begin
        w_eff = flag_q;
        for (int unsigned i = 0; i < NFLAGS; i++) begin
            if (w_pend && r_pmask[i]) begin
                w_eff[i] = r_pdata[i];
            end
            if (w_update && w_mask[i]) begin
                w_eff[i] = alu_flags[i];
            end
        end
    end
`else
    assign stall = br_valid && (w_pend || w_update);

    always_comb begin
        w_eff = flag_q;
    end
`endif

    assign w_br_acc = br_valid && !stall;

    flag_cond_eval #(
        .NFLAGS (NFLAGS)
    ) u_cond (
        .flags   (w_eff),
        .br_cond (br_cond),
        .taken   (w_taken)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pdata     <= '0;
            r_pmask     <= '0;
            r_br_done   <= 1'b0;
            r_br_taken  <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_br_done  <= w_br_acc;
            r_br_taken <= w_br_acc && w_taken;
            if (w_wr) begin
                r_pdata <= w_wr_data;
                r_pmask <= w_wr_mask;
            end
            if (stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + SCNT_W'(1);
            end
        end
    end

    assign br_done   = r_br_done;
    assign br_taken  = r_br_taken;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_flag_ctrl.sv
// Self-checking bench for flag_ctrl: a cycle model pushes expected outputs to a
// scoreboard queue as stimulus is driven; the bench acts as the flag register.
module tb_flag_ctrl;

    logic       clk;
    logic       rst;
    logic       alu_valid;
    logic [3:0] alu_opcode;
    logic [2:0] alu_flags;
    logic       ld_valid;
    logic [2:0] ld_flags;
    logic       ld_ready;
    logic       br_valid;
    logic [2:0] br_cond;
    logic       stall;
    logic       br_done;
    logic       br_taken;
    logic [2:0] flag_d;
    logic [2:0] flag_we;
    logic       flag_re;
    logic [2:0] flag_q;
    logic [7:0] stall_cnt;

    flag_ctrl #(
        .NFLAGS (3),
        .SCNT_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_opcode (alu_opcode),
        .alu_flags  (alu_flags),
        .ld_valid   (ld_valid),
        .ld_flags   (ld_flags),
        .ld_ready   (ld_ready),
        .br_valid   (br_valid),
        .br_cond    (br_cond),
        .stall      (stall),
        .br_done    (br_done),
        .br_taken   (br_taken),
        .flag_d     (flag_d),
        .flag_we    (flag_we),
        .flag_re    (flag_re),
        .flag_q     (flag_q),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       chk_comb;
        logic       e_ldr;
        logic       e_stall;
        logic       e_re;
        logic       e_done;
        logic       e_taken;
        logic [2:0] e_we;
        logic [2:0] e_d;
        logic [7:0] e_cnt;
    } exp_t;

    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    // Model state
    logic       m_pend;
    logic [2:0] m_pd;
    logic [2:0] m_pm;
    logic       m_done;
    logic       m_taken;
    logic [7:0] m_cnt;
    logic [2:0] freg;

    // Observed outputs of the most recent step
    logic       o_ldr;
    logic       o_stall;
    logic       o_done;
    logic       o_taken;
    logic [2:0] o_we;
    logic [2:0] o_d;
    logic [7:0] o_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [2:0] tb_mask(input logic [3:0] op);
        case (op)
            4'd0, 4'd1:             return 3'b111;
            4'd2, 4'd4, 4'd5, 4'd6: return 3'b100;
            default:                return 3'b000;
        endcase
    endfunction

    // f = {Z, V, N}
    function automatic logic tb_cond(input logic [2:0] f, input logic [2:0] cc);
        case (cc)
            3'd0:    return !f[2];
            3'd1:    return f[2];
            3'd2:    return !f[2] && !f[0];
            3'd3:    return f[0];
            3'd4:    return f[2] || !f[0];
            3'd5:    return f[2] || f[0];
            3'd6:    return f[1];
            default: return 1'b1;
        endcase
    endfunction

    task automatic step(input logic av, input logic [3:0] op, input logic [2:0] af,
                        input logic lv, input logic [2:0] lf,
                        input logic bv, input logic [2:0] bc, input logic rs);
        logic [2:0] mask;
        logic       upd;
        logic [2:0] eff;
        logic       stl;
        logic       acc;
        exp_t       e;
        exp_t       g;
        @(negedge clk);
        rst        = rs;
        alu_valid  = av;
        alu_opcode = op;
        alu_flags  = af;
        ld_valid   = lv;
        ld_flags   = lf;
        br_valid   = bv;
        br_cond    = bc;

        mask = tb_mask(op);
        upd  = av && (mask != 3'b000);
        eff  = freg;
`ifdef FLAG_CTRL_FWD_EN
        stl = 1'b0;
        if (m_pend) eff = (eff & ~m_pm) | (m_pd & m_pm);
        if (upd)    eff = (eff & ~mask) | (af & mask);
`else
        stl = bv && (m_pend || upd);
`endif
        e.chk_comb = !rs;
        e.e_ldr    = !upd;
        e.e_stall  = stl;
        e.e_re     = bv;
        e.e_done   = m_done;
        e.e_taken  = m_taken;
        e.e_we     = (m_pend && !rs) ? m_pm : 3'b000;
        e.e_d      = (m_pend && !rs) ? m_pd : 3'b000;
        e.e_cnt    = m_cnt;
        sb.push_back(e);

        #1;
        o_ldr   = ld_ready;
        o_stall = stall;
        o_done  = br_done;
        o_taken = br_taken;
        o_we    = flag_we;
        o_d     = flag_d;
        o_cnt   = stall_cnt;
        g = sb.pop_front();
        if (g.chk_comb) begin
            chk("ld_ready", o_ldr, g.e_ldr);
            chk("stall", o_stall, g.e_stall);
        end
        chk("flag_re", flag_re, g.e_re);
        chk("flag_we", o_we, g.e_we);
        chk("flag_d", o_d, g.e_d);
        chk("br_done", o_done, g.e_done);
        chk("br_taken", o_taken, g.e_taken);
        chk("stall_cnt", o_cnt, g.e_cnt);

        acc = bv && !stl;
        if (rs) begin
            m_pend  = 1'b0;
            m_pd    = 3'b000;
            m_pm    = 3'b000;
            m_done  = 1'b0;
            m_taken = 1'b0;
            m_cnt   = 8'd0;
        end else begin
            m_pend  = upd || lv;
            m_pd    = upd ? af : lf;
            m_pm    = upd ? mask : 3'b111;
            m_done  = acc;
            m_taken = acc && tb_cond(eff, bc);
            if (stl && (m_cnt != 8'hFF)) m_cnt = m_cnt + 8'd1;
        end

        @(posedge clk);
        freg   = (freg & ~o_we) | (o_d & o_we);
        flag_q = freg;
    endtask

    task automatic idle();
        step(1'b0, 4'd0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 4'd0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
    endtask

    task automatic set_flags(input logic [2:0] v);
        freg   = v;
        flag_q = v;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] saved;
        rst = 1'b1; alu_valid = 1'b0; alu_opcode = 4'd0; alu_flags = 3'd0;
        ld_valid = 1'b0; ld_flags = 3'd0; br_valid = 1'b0; br_cond = 3'd0;
        freg = 3'd0; flag_q = 3'd0;
        m_pend = 1'b0; m_pd = 3'd0; m_pm = 3'd0; m_done = 1'b0; m_taken = 1'b0; m_cnt = 8'd0;
        repeat (3) @(posedge clk);

        // Reset state
        idle();
        chk("rst_we", o_we, 3'b000);
        chk("rst_done", o_done, 1'b0);
        chk("rst_cnt", o_cnt, 8'd0);

        // SUB updates all flags one cycle later
        set_flags(3'b100);
        step(1'b1, 4'b0001, 3'b001, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        chk("sub_c0_we", o_we, 3'b000);
        idle();
        chk("sub_c1_we", o_we, 3'b111);
        chk("sub_c1_d", o_d, 3'b001);
        chk("sub_commit", flag_q, 3'b001);

        // ALU wins arbitration over a held restore
        step(1'b1, 4'b0010, 3'b000, 1'b1, 3'b111, 1'b0, 3'd0, 1'b0);
        chk("arb_ldr0", o_ldr, 1'b0);
        step(1'b0, 4'd0, 3'd0, 1'b1, 3'b111, 1'b0, 3'd0, 1'b0);
        chk("arb_ldr1", o_ldr, 1'b1);
        chk("arb_xor_we", o_we, 3'b100);
        idle();
        chk("arb_ld_we", o_we, 3'b111);
        chk("arb_ld_d", o_d, 3'b111);
        idle();
        chk("arb_idle_we", o_we, 3'b000);

        // ADD sets Z together with an EQ branch
        do_reset();
        set_flags(3'b000);
        step(1'b1, 4'b0000, 3'b100, 1'b0, 3'd0, 1'b1, 3'b001, 1'b0);
`ifdef FLAG_CTRL_FWD_EN
        chk("haz_c0_stall", o_stall, 1'b0);
        idle();
        chk("haz_c1_done", o_done, 1'b1);
        chk("haz_c1_taken", o_taken, 1'b1);
        chk("haz_cnt", o_cnt, 8'd0);
        idle();
`else
        chk("haz_c0_stall", o_stall, 1'b1);
        step(1'b0, 4'd0, 3'd0, 1'b0, 3'd0, 1'b1, 3'b001, 1'b0);
        chk("haz_c1_stall", o_stall, 1'b1);
        step(1'b0, 4'd0, 3'd0, 1'b0, 3'd0, 1'b1, 3'b001, 1'b0);
        chk("haz_c2_stall", o_stall, 1'b0);
        idle();
        chk("haz_c3_done", o_done, 1'b1);
        chk("haz_c3_taken", o_taken, 1'b1);
        chk("haz_cnt", o_cnt, 8'd2);
`endif

        // Reset while a write is pending
        set_flags(3'b000);
        step(1'b1, 4'b0000, 3'b111, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        saved = flag_q;
        do_reset();
        chk("rstp_we", o_we, 3'b000);
        chk("rstp_noflag", flag_q, saved);
        idle();
        chk("rstp_we_after", o_we, 3'b000);

        // Long stall saturates the counter
        do_reset();
        repeat (300) step(1'b1, 4'b0000, 3'b000, 1'b0, 3'd0, 1'b1, 3'b111, 1'b0);
`ifdef FLAG_CTRL_FWD_EN
        chk("sat_cnt", o_cnt, 8'd0);
`else
        chk("sat_cnt", o_cnt, 8'hFF);
`endif
        idle();

        // Random traffic against the model
        for (int k = 0; k < 250; k++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 31) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
